ssd_bcd_reader: RTL and testbench
=================================

// Module: ssd_bcd_reader
// PURPOSE
//  Reads back the two-digit seven-segment bus driven by the 00-99 BCD counter and
//  reconstructs the displayed value. Samples both digit patterns, requires them to
//  be stable before accepting, and decodes them to BCD digits plus a binary value.
//  Flags illegal patterns and classifies each new value as a +1 step or a jump.
//  Sits on the display side as the checker/readback for the counter.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical samples needed to accept (range 1..15)
//  BLANK_IS_ZERO  1  1: all-off pattern on tens digit (SSD_in1) decodes as 0, not error
// PORTS
//  Clk      in   1  clock; all state updates on posedge
//  Rst_n    in   1  asynchronous, active-low reset
//  SSD_in0  in   7  units digit segments, active-low, [6:0]=a,b,c,d,e,f,g
//  SSD_in1  in   7  tens digit segments, same encoding
//  Out0     out  4  accepted units digit, BCD
//  Out1     out  4  accepted tens digit, BCD
//  Bin      out  7  accepted value in binary, Out1*10+Out0 (0..99)
//  Valid    out  1  level: at least one good value accepted since reset
//  Update   out  1  1-cycle pulse: accepted value differs from previous or is first
//  Inc      out  1  1-cycle pulse with Update: new = (old+1) mod 100
//  Jump     out  1  1-cycle pulse with Update: not first, not a +1 step
//  Err      out  1  level: last stable pattern pair was illegal
// BEHAVIOUR
//  Legal codes: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100
//    6=0100000 7=0001111 8=0000000 9=0000100. Any other 7-bit pattern is illegal,
//    except 1111111 on SSD_in1 when BLANK_IS_ZERO=1.
//  Reset (async, Rst_n=0): Out0=Out1=0, Bin=0, Valid/Update/Inc/Jump/Err=0.
//    Capture reg=1111111/1111111, stability count=0, FSM=IDLE. Takes effect immediately.
//  Capture: {SSD_in1,SSD_in0} registered every posedge.
//  Stability count: if the new capture equals the held capture, increment (saturate at
//    STABLE_CYCLES). Otherwise clear to 0 and go to SETTLE.
//  FSM: IDLE -(any change)-> SETTLE. IDLE and SETTLE -(count hits STABLE_CYCLES-1)-> ACCEPT.
//    ACCEPT is one cycle; it evaluates and then moves to LOCKED.
//    LOCKED -(capture change)-> SETTLE. No re-accept while the pattern stays stable.
//  Latency: an input stable from posedge k is accepted, and outputs change, at
//    posedge k+STABLE_CYCLES. Any change before that restarts the count.
//  ACCEPT, both digits legal: load Out0/Out1/Bin, Valid=1, Err=0. Pulses:
//    first accept after reset -> Update=1 only; value changed -> Update=1 plus Inc or Jump;
//    value unchanged (glitch then return) -> no pulses.
//  ACCEPT, either digit illegal: Err=1, all value outputs hold, no pulses.
//  Wrap: 99->00 is Inc. 00->00 gives no Update. 05->07 is Jump.
//  Pulse outputs are 0 in every cycle other than the ACCEPT cycle's registered result.
//  Reset asserted mid-SETTLE discards the partial count. Reset has priority over everything.
// STRUCTURE
//  Package ssd_pkg: the ten legal segment codes (SSD_0..SSD_9), SSD_BLANK=7'b1111111,
//    and the FSM state encoding (IDLE, SETTLE, ACCEPT, LOCKED).
//  Sub-module ssd_digit_decode: combinational, 7-bit pattern in -> 4-bit BCD + legal
//    flag (+ blank flag). Instantiated twice.
//  Top: capture reg, stability counter, FSM, BCD->binary (Out1*8+Out1*2+Out0),
//    and +1 mod-100 compare.
// TESTING
//  1 Reset, then hold 0000001/0000001 for 4 clocks -> at edge k+4: Out=00, Bin=0,
//    Valid=1, Update=1, Inc=0, Jump=0.
//  2 Step 23->24, stable 4 clocks -> Update=Inc=1 for one cycle, Bin=24.
//    Then 99->00 -> Inc=1, Bin=0.
//  3 Drive 05, then toggle units between 5 and 7 every 2 clocks for 20 clocks
//    -> no accept; Out stays 05 and no pulses.
//  4 Units=1111110 (illegal) held 4 clocks -> Err=1, Out/Bin unchanged.
//    Then a legal 42 -> Err=0, Update=Jump=1.
//  5 Tens=1111111, units=7 -> Out1=0, Bin=7, Err=0.
//    Same stimulus with BLANK_IS_ZERO=0 -> Err=1.
//  6 Assert Rst_n=0 between clock edges during SETTLE -> all outputs 0 immediately.
//    After release, a stable 31 needs a full 4 clocks and yields a first-accept Update only.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment readback: active-low segment codes
// ([6:0] = a..g) and the acceptance FSM encoding.
package ssd_pkg;

   localparam logic [6:0] SSD_0     = 7'b0000001;
   localparam logic [6:0] SSD_1     = 7'b1001111;
   localparam logic [6:0] SSD_2     = 7'b0010010;
   localparam logic [6:0] SSD_3     = 7'b0000110;
   localparam logic [6:0] SSD_4     = 7'b1001100;
   localparam logic [6:0] SSD_5     = 7'b0100100;
   localparam logic [6:0] SSD_6     = 7'b0100000;
   localparam logic [6:0] SSD_7     = 7'b0001111;
   localparam logic [6:0] SSD_8     = 7'b0000000;
   localparam logic [6:0] SSD_9     = 7'b0000100;
   localparam logic [6:0] SSD_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_ACCEPT,
      ST_LOCKED
   } state_t;

   // tens*10 + units built from shifts: tens*8 + tens*2 + units.
   function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
      return {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, units};
   endfunction

endpackage

// File: rtl/ssd_digit_decode.sv
// Combinational decode of one active-low seven-segment pattern to a BCD digit,
// with a legal-code flag and an all-segments-off flag.
module ssd_digit_decode
   import ssd_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       legal,
   output logic       blank
);

   always_comb begin
      digit = 4'd0;
      legal = 1'b1;
      blank = (seg == SSD_BLANK);
      case (seg)
         SSD_0:   digit = 4'd0;
         SSD_1:   digit = 4'd1;
         SSD_2:   digit = 4'd2;
         SSD_3:   digit = 4'd3;
         SSD_4:   digit = 4'd4;
         SSD_5:   digit = 4'd5;
         SSD_6:   digit = 4'd6;
         SSD_7:   digit = 4'd7;
         SSD_8:   digit = 4'd8;
         SSD_9:   digit = 4'd9;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/ssd_bcd_reader.sv
// Readback checker for a two-digit seven-segment display: debounces the segment
// bus, decodes it to BCD/binary, flags illegal patterns and classifies steps.
module ssd_bcd_reader
   import ssd_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter bit BLANK_IS_ZERO = 1'b1
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [6:0] SSD_in0,
   input  logic [6:0] SSD_in1,
   output logic [3:0] Out0,
   output logic [3:0] Out1,
   output logic [6:0] Bin,
   output logic       Valid,
   output logic       Update,
   output logic       Inc,
   output logic       Jump,
   output logic       Err
);

   localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
   localparam logic [3:0] ACC_AT  = 4'(STABLE_CYCLES - 1);

   logic [1:0][6:0] cap_q, cap_d;
   logic [3:0]      cnt_q, cnt_d;
   state_t          state_q, state_d;
   logic [3:0]      out0_q, out0_d, out1_q, out1_d;
   logic [6:0]      bin_q, bin_d;
   logic            valid_q, valid_d;
   logic            update_q, update_d;
   logic            inc_q, inc_d;
   logic            jump_q, jump_d;
   logic            err_q, err_d;

   logic [1:0][3:0] dig;
   logic [1:0]      legal;
   logic [1:0]      blank;
   logic [1:0]      digit_ok;
   logic            same;
   logic [3:0]      cnt_inc;
   logic [6:0]      new_bin;
   logic [6:0]      next_bin;

   // Index 0 = units (SSD_in0), index 1 = tens (SSD_in1); only tens may be blank.
   for (genvar g = 0; g < 2; g++) begin : g_dig
      ssd_digit_decode u_dec (
         .seg   (cap_q[g]),
         .digit (dig[g]),
         .legal (legal[g]),
         .blank (blank[g])
      );
      assign digit_ok[g] = legal[g] | (blank[g] & (BLANK_IS_ZERO && g == 1));
   end

   assign same     = ({SSD_in1, SSD_in0} == cap_q);
   assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
   assign new_bin  = bcd_to_bin(dig[1], dig[0]);
   assign next_bin = (bin_q == 7'd99) ? 7'd0 : bin_q + 7'd1;

   always_comb begin
      cap_d    = {SSD_in1, SSD_in0};
      cnt_d    = cnt_q;
      state_d  = state_q;
      out0_d   = out0_q;
      out1_d   = out1_q;
      bin_d    = bin_q;
      valid_d  = valid_q;
      err_d    = err_q;
      update_d = 1'b0;
      inc_d    = 1'b0;
      jump_d   = 1'b0;

      if (!same) begin
         // A change always restarts the count; with a one-cycle window it is already due.
         cnt_d   = '0;
         state_d = (ACC_AT == 4'd0) ? ST_ACCEPT : ST_SETTLE;
      end else begin
         cnt_d = cnt_inc;
         case (state_q)
            ST_IDLE, ST_SETTLE: begin
               if (cnt_inc >= ACC_AT) state_d = ST_ACCEPT;
            end
            ST_ACCEPT: begin
               state_d = ST_LOCKED;
               if (&digit_ok) begin
                  out0_d  = dig[0];
                  out1_d  = dig[1];
                  bin_d   = new_bin;
                  valid_d = 1'b1;
                  err_d   = 1'b0;
                  if (!valid_q) begin
                     update_d = 1'b1;
                  end else if (new_bin != bin_q) begin
                     update_d = 1'b1;
                     inc_d    = (new_bin == next_bin);
                     jump_d   = (new_bin != next_bin);
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            default: state_d = ST_LOCKED;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cap_q    <= {SSD_BLANK, SSD_BLANK};
         cnt_q    <= '0;
         state_q  <= ST_IDLE;
         out0_q   <= '0;
         out1_q   <= '0;
         bin_q    <= '0;
         valid_q  <= 1'b0;
         update_q <= 1'b0;
         inc_q    <= 1'b0;
         jump_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         cap_q    <= cap_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         out0_q   <= out0_d;
         out1_q   <= out1_d;
         bin_q    <= bin_d;
         valid_q  <= valid_d;
         update_q <= update_d;
         inc_q    <= inc_d;
         jump_q   <= jump_d;
         err_q    <= err_d;
      end
   end

   assign Out0   = out0_q;
   assign Out1   = out1_q;
   assign Bin    = bin_q;
   assign Valid  = valid_q;
   assign Update = update_q;
   assign Inc    = inc_q;
   assign Jump   = jump_q;
   assign Err    = err_q;

endmodule

// File: tb/tb_ssd_bcd_reader.sv
// Bench for ssd_bcd_reader: directed scenarios plus random segment streams,
// compared each cycle against a run-length model of the acceptance rules.
module tb_ssd_bcd_reader;

   localparam int S = 4;

   logic       clk;
   logic       rst_n;
   logic [6:0] t_seg, u_seg;

   logic [3:0] out0, out1, b_out0, b_out1;
   logic [6:0] bin, b_bin;
   logic       valid, update, inc, jump, err;
   logic       b_valid, b_update, b_inc, b_jump, b_err;

   int n_checks = 0;
   int n_fail   = 0;

   ssd_bcd_reader #(.STABLE_CYCLES(S), .BLANK_IS_ZERO(1'b1)) dut (
      .Clk(clk), .Rst_n(rst_n), .SSD_in0(u_seg), .SSD_in1(t_seg),
      .Out0(out0), .Out1(out1), .Bin(bin), .Valid(valid),
      .Update(update), .Inc(inc), .Jump(jump), .Err(err)
   );

   ssd_bcd_reader #(.STABLE_CYCLES(S), .BLANK_IS_ZERO(1'b0)) dut_b (
      .Clk(clk), .Rst_n(rst_n), .SSD_in0(u_seg), .SSD_in1(t_seg),
      .Out0(b_out0), .Out1(b_out1), .Bin(b_bin), .Valid(b_valid),
      .Update(b_update), .Inc(b_inc), .Jump(b_jump), .Err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic int dec(input logic [6:0] p);
      for (int i = 0; i < 10; i++) if (seg(i) == p) return i;
      return -1;
   endfunction

   // Reference model: a pair is accepted exactly S edges after the edge that first
   // sampled it (reset counts as having sampled blank/blank at edge 0).
   logic [3:0]  exp_out0, exp_out1;
   logic [6:0]  exp_bin;
   logic        exp_valid, exp_upd, exp_inc, exp_jump, exp_err;
   logic [13:0] last_pair;
   int          edge_n, run_start, m_t, m_u, m_v;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {exp_out0, exp_out1, exp_bin} = '0;
         {exp_valid, exp_upd, exp_inc, exp_jump, exp_err} = '0;
         last_pair = 14'h3fff;
         edge_n    = 0;
         run_start = 0;
      end else begin
         edge_n++;
         if ({t_seg, u_seg} != last_pair) begin
            last_pair = {t_seg, u_seg};
            run_start = edge_n;
         end
         exp_upd  = 1'b0;
         exp_inc  = 1'b0;
         exp_jump = 1'b0;
         if (edge_n - run_start == S) begin
            m_u = dec(last_pair[6:0]);
            m_t = (last_pair[13:7] == 7'h7f) ? 0 : dec(last_pair[13:7]);
            if (m_u >= 0 && m_t >= 0) begin
               m_v = m_t * 10 + m_u;
               if (!exp_valid) exp_upd = 1'b1;
               else if (m_v != int'(exp_bin)) begin
                  exp_upd  = 1'b1;
                  exp_inc  = (m_v == (int'(exp_bin) + 1) % 100);
                  exp_jump = !exp_inc;
               end
               exp_out0  = 4'(m_u);
               exp_out1  = 4'(m_t);
               exp_bin   = 7'(m_v);
               exp_valid = 1'b1;
               exp_err   = 1'b0;
            end else begin
               exp_err = 1'b1;
            end
         end
      end
   end

   wire [19:0] obs     = {out1, out0, bin, valid, update, inc, jump, err};
   wire [19:0] exp_vec = {exp_out1, exp_out0, exp_bin, exp_valid, exp_upd, exp_inc, exp_jump, exp_err};

   task automatic drive(input int tens, input int units);
      t_seg = seg(tens);
      u_seg = seg(units);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drive(0, 0);
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (obs !== 20'h0 || b_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: outputs %h (b_valid %b), required all zero", obs, b_valid);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_first_accept;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (obs !== exp_vec) begin
            n_fail++; $display("FAIL first_model cyc %0d: got %h, model %h", i, obs, exp_vec);
         end
         n_checks++;
         if (i < 5 && valid !== 1'b0) begin
            n_fail++; $display("FAIL first_early cyc %0d: valid %b, required 0", i, valid);
         end else if (i == 5 && {out1, out0, bin, valid, update, inc, jump} !== {15'd0, 4'b1100}) begin
            n_fail++; $display("FAIL first_accept: got %h, required out=00 bin=0 valid upd only", obs);
         end else if (i == 6 && update !== 1'b0) begin
            n_fail++; $display("FAIL first_pulse_len: update %b, required 0", update);
         end
      end
   endtask

   task automatic test_step;
      drive(2, 3);
      repeat (6) begin
         @(posedge clk); #1;
         n_checks++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL step_23 got %h, model %h", obs, exp_vec); end
      end
      drive(2, 4);
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL step_24 cyc %0d got %h, model %h", i, obs, exp_vec); end
         if (i == 5) begin
            n_checks++;
            if (update !== 1'b1 || inc !== 1'b1 || jump !== 1'b0 || bin !== 7'd24) begin
               n_fail++; $display("FAIL step_inc: upd %b inc %b jump %b bin %0d, required 1 1 0 24", update, inc, jump, bin);
            end
         end
      end
      drive(9, 9);
      repeat (6) begin
         @(posedge clk); #1;
         n_checks++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL step_99 got %h, model %h", obs, exp_vec); end
      end
      drive(0, 0);
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL wrap cyc %0d got %h, model %h", i, obs, exp_vec); end
         if (i == 5) begin
            n_checks++;
            if (update !== 1'b1 || inc !== 1'b1 || bin !== 7'd0) begin
               n_fail++; $display("FAIL wrap_inc: upd %b inc %b bin %0d, required 1 1 0", update, inc, bin);
            end
         end
      end
   endtask

   task automatic test_glitch;
      drive(0, 5);
      repeat (6) begin
         @(posedge clk); #1;
         n_checks++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL glitch_05 got %h, model %h", obs, exp_vec); end
      end
      for (int j = 0; j < 10; j++) begin
         drive(0, (j % 2 == 0) ? 7 : 5);
         repeat (2) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== exp_vec || update !== 1'b0 || bin !== 7'd5) begin
               n_fail++; $display("FAIL glitch_toggle %0d: got %h, model %h, required bin 5 no pulse", j, obs, exp_vec);
            end
         end
      end
      repeat (6) begin
         @(posedge clk); #1;
         n_checks++;
         if (obs !== exp_vec || update !== 1'b0 || bin !== 7'd5) begin
            n_fail++; $display("FAIL glitch_return: got %h, model %h, required bin 5 no pulse", obs, exp_vec);
         end
      end
   endtask

   task automatic test_illegal;
      t_seg = seg(0);
      u_seg = 7'b1111110;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL illegal cyc %0d got %h, model %h", i, obs, exp_vec); end
         if (i == 5) begin
            n_checks++;
            if (err !== 1'b1 || bin !== 7'd5 || update !== 1'b0) begin
               n_fail++; $display("FAIL illegal_err: err %b bin %0d upd %b, required 1 5 0", err, bin, update);
            end
         end
      end
      drive(4, 2);
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL recover cyc %0d got %h, model %h", i, obs, exp_vec); end
         if (i == 5) begin
            n_checks++;
            if (err !== 1'b0 || update !== 1'b1 || jump !== 1'b1 || bin !== 7'd42) begin
               n_fail++; $display("FAIL recover_jump: err %b upd %b jump %b bin %0d, required 0 1 1 42", err, update, jump, bin);
            end
         end
      end
   endtask

   task automatic test_blank;
      t_seg = 7'b1111111;
      u_seg = seg(7);
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL blank cyc %0d got %h, model %h", i, obs, exp_vec); end
         if (i == 5) begin
            n_checks++;
            if (out1 !== 4'd0 || bin !== 7'd7 || err !== 1'b0) begin
               n_fail++; $display("FAIL blank_zero: out1 %0d bin %0d err %b, required 0 7 0", out1, bin, err);
            end
            n_checks++;
            if (b_err !== 1'b1 || b_bin !== 7'd42 || b_update !== 1'b0) begin
               n_fail++; $display("FAIL blank_strict: err %b bin %0d upd %b, required 1 42 0", b_err, b_bin, b_update);
            end
         end
      end
   endtask

   task automatic test_reset_mid_settle;
      drive(1, 2);
      repeat (2) @(posedge clk);
      #4;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== 20'h0 || b_err !== 1'b0 || b_bin !== 7'd0) begin
         n_fail++; $display("FAIL reset_async: outputs %h, required all zero", obs);
      end
      drive(3, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (obs !== exp_vec) begin n_fail++; $display("FAIL post_reset cyc %0d got %h, model %h", i, obs, exp_vec); end
         n_checks++;
         if (i < 5 && valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_early cyc %0d: valid %b, required 0", i, valid);
         end else if (i == 5 && {bin, valid, update, inc, jump} !== {7'd31, 4'b1100}) begin
            n_fail++; $display("FAIL post_reset_accept: bin %0d v/u/i/j %b%b%b%b, required 31 1100", bin, valid, update, inc, jump);
         end
      end
   endtask

   task automatic test_random;
      int cur_v, v, r, hold;
      cur_v = 31;
      for (int n = 0; n < 60; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6 || r == 6) begin
            v = (r == 6) ? (cur_v + 1) % 100 : int'($urandom_range(0, 99));
            drive(v / 10, v % 10);
            cur_v = v;
         end else if (r == 7) begin
            drive(cur_v / 10, cur_v % 10);
         end else if (r == 8) begin
            t_seg = seg(int'($urandom_range(0, 9)));
            u_seg = 7'($urandom);
         end else begin
            t_seg = 7'b1111111;
            u_seg = seg(int'($urandom_range(0, 9)));
         end
         hold = int'($urandom_range(1, 7));
         repeat (hold) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== exp_vec) begin
               n_fail++; $display("FAIL random seg %0d: got %h, model %h", n, obs, exp_vec);
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_first_accept;
      test_step;
      test_glitch;
      test_illegal;
      test_blank;
      test_reset_mid_settle;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
